// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback
//   Register-file writeback arbiter. It merges two result streams into the
//   single register-file write port:
//     - port A: single-cycle ALU results, which have priority
//     - port M: long-latency load/mul results, held in a 4-entry in-order FIFO
//   A starvation counter keeps M from waiting forever. After STARVE_MAX
//   consecutive A wins while M entries wait, the arbiter enters FORCE_DRAIN
//   for one cycle. In that cycle A is stalled and one FIFO entry is written.
//
// Parameters
//   STARVE_MAX  maximum consecutive A grants while FIFO entries wait (>= 1)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_valid/a_addr/a_data      ALU result in;           a_ready handshake out
//   m_valid/m_addr/m_data      load/mul result in;      m_ready handshake out
//   wr_enable/wr_addr/wr_data  registered register-file write port
//   fifo_count                 M-FIFO occupancy, 0..4
//   busy                       FIFO non-empty or a write is on wr_*
//
// Optional feature (macro WB_FWD_EN)
//   rd_addr1/rd_addr2          register read addresses in
//   fwd_hit1/fwd_hit2          the current write targets that read address
//   fwd_data1/fwd_data2        forwarded write data, 0 when there is no hit
// ---------------------------------------------------------------------------
module reg_writeback #(
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        m_valid,
  input  logic [4:0]  m_addr,
  input  logic [31:0] m_data,
  output logic        m_ready,
`ifdef WB_FWD_EN
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2,
`endif
  output logic        wr_enable,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [2:0]  fifo_count,
  output logic        busy
);

  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic {
    NORMAL,
    FORCE_DRAIN
  } mode_t;

  mode_t          mode, mode_nxt;
  logic [SW-1:0]  starve_cnt, starve_nxt;

  logic [4:0]     fifo_addr [4];
  logic [31:0]    fifo_data [4];
  logic [1:0]     rd_ptr, wr_ptr;
  logic [2:0]     count, count_nxt;

  logic           a_acc, m_acc, push, pop;
  logic           wr_enable_nxt;
  logic [4:0]     grant_addr;
  logic [31:0]    grant_data;

  // Handshakes, grant selection and FIFO occupancy.
  // A full FIFO refuses M even if it pops this cycle, so m_ready depends
  // only on registered state. An M result for r0 is accepted and dropped.
  always_comb begin
    a_ready    = (mode == NORMAL);
    m_ready    = (count < 3'd4);
    a_acc      = a_valid && a_ready;
    m_acc      = m_valid && m_ready;
    push       = m_acc && (m_addr != 5'd0);
    pop        = !a_acc && (count != 3'd0);
    grant_addr = a_addr;
    grant_data = a_data;
    if (pop) begin
      grant_addr = fifo_addr[rd_ptr];
      grant_data = fifo_data[rd_ptr];
    end
    wr_enable_nxt = (a_acc || pop) && (grant_addr != 5'd0);
    case ({push, pop})
      2'b10:   count_nxt = count + 3'd1;
      2'b01:   count_nxt = count - 3'd1;
      default: count_nxt = count;
    endcase
  end

  // Starvation tracking and the arbiter mode.
  // The mode uses the next starve value, so the cycle after the
  // STARVE_MAX-th A win is already the drain cycle.
  always_comb begin
    starve_nxt = starve_cnt;
    if (pop || (count == 3'd0)) begin
      starve_nxt = '0;
    end else if (a_acc && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_nxt = starve_cnt + SW'(1);
    end
    mode_nxt = mode;
    case (mode)
      NORMAL: begin
        if ((starve_nxt == SW'(STARVE_MAX)) && (count_nxt != 3'd0)) begin
          mode_nxt = FORCE_DRAIN;
        end
      end
      FORCE_DRAIN: mode_nxt = NORMAL;
      default:     mode_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode       <= NORMAL;
      starve_cnt <= '0;
      count      <= 3'd0;
      rd_ptr     <= 2'd0;
      wr_ptr     <= 2'd0;
      wr_enable  <= 1'b0;
      wr_addr    <= 5'd0;
      wr_data    <= 32'd0;
    end else begin
      mode       <= mode_nxt;
      starve_cnt <= starve_nxt;
      count      <= count_nxt;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      wr_enable  <= wr_enable_nxt;
      wr_addr    <= wr_enable_nxt ? grant_addr : 5'd0;
      wr_data    <= wr_enable_nxt ? grant_data : 32'd0;
    end
  end

  // FIFO storage. It has no reset because the pointers and count define
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= m_addr;
      fifo_data[wr_ptr] <= m_data;
    end
  end

  assign fifo_count = count;
  assign busy       = (count != 3'd0) || wr_enable;

`ifdef WB_FWD_EN
  assign fwd_hit1  = wr_enable && (wr_addr == rd_addr1) && (rd_addr1 != 5'd0);
  assign fwd_hit2  = wr_enable && (wr_addr == rd_addr2) && (rd_addr2 != 5'd0);
  assign fwd_data1 = fwd_hit1 ? wr_data : 32'd0;
  assign fwd_data2 = fwd_hit2 ? wr_data : 32'd0;
`endif

endmodule
